// File: rtl/hist_eq_lut_builder_if.sv
// Bus bundle for hist_eq_lut_builder: start/cdfMin request, CDF memory read port,
// remap LUT write port and busy/done status.
interface hist_eq_lut_builder_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned outWidth  = 19
);
  logic                 i_start;
  logic [outWidth-1:0]  i_cdfMin;
  logic [DataWidth-1:0] o_cdf_addr;
  logic [outWidth-1:0]  i_cdf_data;
  logic                 o_lut_wr_en;
  logic [DataWidth-1:0] o_lut_wr_addr;
  logic [DataWidth-1:0] o_lut_wr_data;
  logic                 o_busy;
  logic                 o_done;

  modport slave (
    input  i_start, i_cdfMin, i_cdf_data,
    output o_cdf_addr, o_lut_wr_en, o_lut_wr_addr, o_lut_wr_data, o_busy, o_done
  );

  modport master (
    output i_start, i_cdfMin, i_cdf_data,
    input  o_cdf_addr, o_lut_wr_en, o_lut_wr_addr, o_lut_wr_data, o_busy, o_done
  );
endinterface

// File: rtl/hist_eq_lut_builder.sv
// Builds the histogram-equalization remap LUT from the frame CDF with a restoring divider.
// Define HIST_EQ_ROUND_EN for round-half-up levels; otherwise levels are truncated.
module hist_eq_lut_builder #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned TotalPixels = 640*480,
  parameter int unsigned outWidth    = $clog2(TotalPixels)
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  hist_eq_lut_builder_if.slave bus
);

  localparam int unsigned ProdW = outWidth + DataWidth;
  localparam int unsigned CntW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [DataWidth-1:0] LastBin  = '1;
  localparam logic [DataWidth-1:0] MaxLevel = '1;
  localparam logic [outWidth:0]    Total    = (outWidth+1)'(TotalPixels);
  localparam logic [CntW-1:0]      LastBit  = CntW'(DataWidth - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CALC, S_DIV, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DataWidth-1:0] index_q;
  logic [outWidth-1:0]  cdf_min_q;
  logic [outWidth:0]    den_q;
  logic [outWidth:0]    rem_q;
  logic [DataWidth-1:0] dvd_q;
  logic [CntW-1:0]      cnt_q;
  logic [DataWidth-1:0] wr_addr_q;
  logic [DataWidth-1:0] wr_data_q;

  logic [outWidth:0]    den_c;
  logic [outWidth-1:0]  diff_c;
  logic [ProdW-1:0]     num_c;
  logic [ProdW-1:0]     dividend_c;
  logic                 special_c;
  logic [DataWidth-1:0] special_val_c;
  logic [outWidth+1:0]  trial_c;
  logic [outWidth:0]    rem_sub_c;
  logic                 ge_c;
  logic [outWidth:0]    rem_next_c;

  always_comb begin
    den_c  = Total - {1'b0, cdf_min_q};
    diff_c = bus.i_cdf_data - cdf_min_q;
    num_c  = ProdW'(diff_c) * ProdW'(MaxLevel);
`ifdef HIST_EQ_ROUND_EN
    dividend_c = num_c + ProdW'(den_c >> 1);
`else
    dividend_c = num_c;
`endif
    special_c     = 1'b0;
    special_val_c = '0;
    // A single-valued frame (den == 0) maps to identity and wins over the cdf <= cdfMin case.
    if (den_c == '0) begin
      special_c     = 1'b1;
      special_val_c = index_q;
    end else if (bus.i_cdf_data <= cdf_min_q) begin
      special_c = 1'b1;
    end

    // Trial subtract kept to outWidth+1 bits; the carried-out top bit alone forces a 1.
    trial_c    = {rem_q, dvd_q[DataWidth-1]};
    rem_sub_c  = trial_c[outWidth:0] - den_q;
    ge_c       = trial_c[outWidth+1] | (trial_c[outWidth:0] >= den_q);
    rem_next_c = ge_c ? rem_sub_c : trial_c[outWidth:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.o_lut_wr_en = 1'b0;
    bus.o_busy      = 1'b1;
    bus.o_done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.o_busy = 1'b0;
        if (bus.i_start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_CALC;
      S_CALC:  state_d = special_c ? S_WRITE : S_DIV;
      S_DIV:   if (cnt_q == LastBit) state_d = S_WRITE;
      S_WRITE: begin
        bus.o_lut_wr_en = 1'b1;
        state_d = (index_q == LastBin) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Quotient bits shift into dvd_q as the dividend bits are consumed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      index_q   <= '0;
      cdf_min_q <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          index_q <= '0;
          if (bus.i_start) cdf_min_q <= bus.i_cdfMin;
        end
        S_CALC: begin
          den_q <= den_c;
          rem_q <= {1'b0, dividend_c[ProdW-1:DataWidth]};
          dvd_q <= dividend_c[DataWidth-1:0];
          cnt_q <= '0;
          if (special_c) begin
            wr_addr_q <= index_q;
            wr_data_q <= special_val_c;
          end
        end
        S_DIV: begin
          rem_q <= rem_next_c;
          dvd_q <= {dvd_q[DataWidth-2:0], ge_c};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            wr_addr_q <= index_q;
            wr_data_q <= {dvd_q[DataWidth-2:0], ge_c};
          end
        end
        S_WRITE: if (index_q != LastBin) index_q <= index_q + DataWidth'(1);
        default: ;
      endcase
    end
  end

  assign bus.o_cdf_addr    = index_q;
  assign bus.o_lut_wr_addr = wr_addr_q;
  assign bus.o_lut_wr_data = wr_data_q;

endmodule

// File: doc/hist_eq_lut_builder.md
# hist_eq_lut_builder

Downstream stage of the histogram equalization pipeline. It consumes the minimum non-zero CDF value (cdfMin) and the per-bin cumulative histogram (CDF) memory once a frame is complete. It walks every intensity bin and computes the equalized output level with a sequential divider, then writes it into the remap LUT used by the pixel-mapping stage. It runs once per frame between frame end and the next frame's remap.

## Interface
Parameters:
- DataWidth, 8, pixel width; the LUT has 2**DataWidth entries.
- TotalPixels, 640*480, pixels per frame (N).
- outWidth, $clog2(TotalPixels), width of CDF values and cdfMin.

Ports:
- i_clk  input  1  single clock; all logic is on its rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle request to build the LUT; honoured only in IDLE.
- i_cdfMin  input  outWidth  minimum non-zero CDF; sampled on the accepted i_start.
- o_cdf_addr  output  DataWidth  CDF memory read address (registered).
- i_cdf_data  input  outWidth  CDF read data, valid one cycle after o_cdf_addr changes.
- o_lut_wr_en  output  1  LUT write strobe, one cycle per bin.
- o_lut_wr_addr  output  DataWidth  LUT write address (equals current bin).
- o_lut_wr_data  output  DataWidth  equalized level.
- o_busy  output  1  high from the cycle after the accepted i_start until DONE exits.
- o_done  output  1  one-cycle pulse after the last LUT write.

## Operation
- Mapping per bin v with cdf = CDF[v]: den = TotalPixels - cdfMin; num = (cdf - cdfMin) * (2**DataWidth - 1); out = (num + (den >> 1)) / den (rounded; see Configuration).
- Special cases, written without division: cdf <= cdfMin -> out = 0; den == 0 (single-valued frame) -> out = v (identity).
- The multiply result uses outWidth+DataWidth bits. The restoring divider produces DataWidth quotient bits MSB-first, one per cycle, with an outWidth+1 bit remainder. No overflow can occur because num + den/2 < den * 2**DataWidth.
- FSM states:
  - IDLE: index = 0; accepted i_start latches i_cdfMin -> FETCH.
  - FETCH: o_cdf_addr = index; wait one cycle for memory -> CALC.
  - CALC: capture i_cdf_data, form num and den; special case -> WRITE; else -> DIV.
  - DIV: DataWidth cycles, then -> WRITE.
  - WRITE: assert o_lut_wr_en with addr = index. If index == 2**DataWidth-1 -> DONE; else index+1 -> FETCH.
  - DONE: o_done = 1 -> IDLE.
- i_start while busy is ignored. i_cdfMin changes after acceptance have no effect.

## Timing
- Reset values: o_cdf_addr 0, o_lut_wr_en 0, o_lut_wr_addr 0, o_lut_wr_data 0, o_busy 0, o_done 0; FSM returns to IDLE.
- Cycles per bin: DataWidth + 3 when dividing (11 at default), 3 for special cases.
- Full build at DataWidth = 8 with no special bins: 256 * 11 + 1 (DONE) cycles after FETCH entry.
- o_busy rises the cycle after i_start and falls in the same cycle o_done falls.
- Reset mid-build: immediate abort with no further LUT writes. Partially written LUT contents are undefined; a new i_start is required.
- o_lut_wr_addr/o_lut_wr_data are valid only while o_lut_wr_en is high. Otherwise they hold their last values.

## Configuration
- HIST_EQ_ROUND_EN defined: rounding term den >> 1 is added before division (round-half-up).
- HIST_EQ_ROUND_EN undefined: out = num / den (truncation). The rounding adder is removed. Latency is unchanged.

## Test plan
- Reset: assert i_reset_n = 0 mid-DIV -> all outputs 0 immediately, no o_lut_wr_en afterwards, o_done never pulses.
- Ramp: TotalPixels = 16, cdfMin = 4, CDF[v] = 10 -> out 128 with HIST_EQ_ROUND_EN, 127 without. CDF[v] = 16 -> 255.
- Flat frame: cdfMin = TotalPixels -> every LUT entry v = v, 3 cycles per bin, total 769 cycles, exactly 256 writes.
- Zero bins: CDF[0..9] = 0, cdfMin = 5 -> entries 0..9 = 0, each written in 3 cycles.
- Handshake: i_start pulsed again while o_busy = 1 -> ignored. A single o_done occurs after the 256th write, and o_busy = 0 the cycle after. A new i_start then re-runs from bin 0.
- Latency: default parameters, uniform CDF (CDF[v] = 1200*(v+1), cdfMin = 1200) -> exactly 11 cycles between consecutive o_lut_wr_en pulses; entry 255 = 255.
